// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit
//   Pipeline interlock for the MIPS32 pipeline. A shift-register scoreboard
//   follows every in-flight register writer from EX up to (but excluding) WB.
//   The ID-stage sources are compared against it to decide whether the ID
//   instruction may issue this edge.
//
//   Optional feature macro: MIPS_HAZ_FWD_EN
//     defined   - only load-use on sb[0] interlocks; other matches are
//                 resolved through registered forwarding selects.
//     undefined - any match interlocks; fwd_a / fwd_b are tied to 0.
//
//   Parameters: REG_AW (register address width), DEPTH (tracked stages,
//   2..4), CNT_W (stall counter width), FS_W (derived select width).
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     id_valid                    ID holds a live instruction
//     id_rs, id_rt                source registers of the ID instruction
//     id_use_rs, id_use_rt        the instruction really reads rs / rt
//     id_wr, id_rd, id_load       destination info of the ID instruction
//     br_taken                    branch in EX resolved taken
//     id_ready                    ID instruction issues to EX at this edge
//     stall                       hold PC and IF_ID
//     flush                       clear IF_ID, bubble into ID_EX
//     fwd_a, fwd_b                EX operand source (0 = ID_EX, k = stage k)
//     busy                        any scoreboard entry valid
//     stall_cnt                   saturating count of stall cycles
module mips_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  localparam int FS_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_load,
  input  logic              br_taken,
  output logic              id_ready,
  output logic              stall,
  output logic              flush,
  output logic [FS_W-1:0]   fwd_a,
  output logic [FS_W-1:0]   fwd_b,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Scoreboard: index 0 is the instruction in EX, index i is i stages beyond.
  logic [DEPTH-1:0]  sb_v_reg;
  logic [REG_AW-1:0] sb_rd_reg [DEPTH];

  logic [DEPTH-1:0]  match_a;
  logic [DEPTH-1:0]  match_b;
  logic              rs_live;
  logic              rt_live;
  logic              hazard;
  logic              issue_wr;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  assign rs_live = id_valid & id_use_rs & (id_rs != '0);
  assign rt_live = id_valid & id_use_rt & (id_rt != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_a[gi] = rs_live & sb_v_reg[gi] & (sb_rd_reg[gi] == id_rs);
      assign match_b[gi] = rt_live & sb_v_reg[gi] & (sb_rd_reg[gi] == id_rt);
    end
  endgenerate

`ifdef MIPS_HAZ_FWD_EN
  // Only the load flag of the EX entry is ever consulted: a load that has
  // moved past EX can be forwarded from its later stage, so it is kept for
  // sb[0] alone.
  logic ld0_reg;
  assign hazard = (match_a[0] | match_b[0]) & ld0_reg;
`else
  logic unused_load;
  assign unused_load = id_load;
  assign hazard = (|match_a) | (|match_b);
`endif

  assign id_ready = id_valid & ~br_taken & ~hazard;
  assign stall    = id_valid & ~id_ready & ~br_taken;
  assign flush    = br_taken;
  assign busy     = |sb_v_reg;
  assign issue_wr = id_ready & id_wr & (id_rd != '0);

  // A blocked or killed instruction inserts a bubble while older writers keep
  // advancing, so every hazard drains by shifting alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_rd_reg[i] <= '0;
      end
    end else begin
      sb_v_reg <= {sb_v_reg[DEPTH-2:0], issue_wr};
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_rd_reg[i] <= sb_rd_reg[i-1];
      end
      sb_rd_reg[0] <= issue_wr ? id_rd : '0;
    end
  end

`ifdef MIPS_HAZ_FWD_EN
  logic [FS_W-1:0] fwd_a_next;
  logic [FS_W-1:0] fwd_b_next;
  logic [FS_W-1:0] fwd_a_reg;
  logic [FS_W-1:0] fwd_b_reg;

  // Youngest producer wins: scan oldest to youngest so the lowest index
  // overwrites any older match.
  always_comb begin
    fwd_a_next = '0;
    fwd_b_next = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (match_a[j]) fwd_a_next = FS_W'(j + 1);
      if (match_b[j]) fwd_b_next = FS_W'(j + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld0_reg   <= 1'b0;
      fwd_a_reg <= '0;
      fwd_b_reg <= '0;
    end else begin
      ld0_reg   <= issue_wr & id_load;
      fwd_a_reg <= id_ready ? fwd_a_next : '0;
      fwd_b_reg <= id_ready ? fwd_b_next : '0;
    end
  end

  assign fwd_a = fwd_a_reg;
  assign fwd_b = fwd_b_reg;
`else
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Bench for mips_hazard_unit (DEPTH = 2). Two instances share the stimulus:
// one with a 16-bit stall counter, one with a 4-bit counter for saturation.
module tb_mips_hazard_unit;
  localparam int DEPTH  = 2;
  localparam int REG_AW = 5;
`ifdef MIPS_HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              id_valid, id_use_rs, id_use_rt, id_wr, id_load, br_taken;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_ready, stall, flush, busy;
  logic [1:0]        fwd_a, fwd_b;
  logic [15:0]       stall_cnt;
  logic              id_ready4, stall4, flush4, busy4;
  logic [1:0]        fwd_a4, fwd_b4;
  logic [3:0]        stall_cnt4;

  mips_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
    .id_load(id_load), .br_taken(br_taken), .id_ready(id_ready), .stall(stall),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy), .stall_cnt(stall_cnt));

  mips_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
    .id_load(id_load), .br_taken(br_taken), .id_ready(id_ready4), .stall(stall4),
    .flush(flush4), .fwd_a(fwd_a4), .fwd_b(fwd_b4), .busy(busy4), .stall_cnt(stall_cnt4));

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight writers listed with their age (0 = in EX); they drop out once
  // they reach WB.
  typedef struct {
    logic [4:0] rd;
    bit         ld;
    int         stage;
  } wr_t;
  wr_t pend[$];
  int  m_fa, m_fb, m_cnt16, m_cnt4;
  bit  e_ready, e_stall, e_busy;
  int  e_fa_next, e_fb_next;

  function automatic void scan(input logic [4:0] src, input bit use_s,
                               output int young, output bit haz);
    young = -1;
    haz   = 1'b0;
    if (id_valid && use_s && src != 0) begin
      foreach (pend[k]) begin
        if (pend[k].rd == src) begin
          if (young < 0 || pend[k].stage < young) young = pend[k].stage;
          if (!FWD || (pend[k].stage == 0 && pend[k].ld)) haz = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_eval();
    int ya, yb;
    bit ha, hb;
    scan(id_rs, id_use_rs, ya, ha);
    scan(id_rt, id_use_rt, yb, hb);
    e_ready   = id_valid && !br_taken && !(ha || hb);
    e_stall   = id_valid && !e_ready && !br_taken;
    e_busy    = pend.size() != 0;
    e_fa_next = (FWD && e_ready && ya >= 0) ? ya + 1 : 0;
    e_fb_next = (FWD && e_ready && yb >= 0) ? yb + 1 : 0;
  endfunction

  function automatic void model_edge();
    wr_t nq[$];
    wr_t w;
    foreach (pend[k]) begin
      if (pend[k].stage + 1 < DEPTH) begin
        w = pend[k];
        w.stage++;
        nq.push_back(w);
      end
    end
    if (e_ready && id_wr && id_rd != 0) begin
      w.rd = id_rd; w.ld = id_load; w.stage = 0;
      nq.push_front(w);
    end
    pend = nq;
    m_fa = e_fa_next;
    m_fb = e_fb_next;
    if (e_stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endfunction

  function automatic void model_reset();
    pend.delete();
    m_fa = 0; m_fb = 0; m_cnt16 = 0; m_cnt4 = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input int rd, input bit ld, input bit br);
    id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
    id_wr = wr; id_rd = 5'(rd); id_load = ld; br_taken = br;
  endtask

  task automatic check_cycle(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, " ready"}, id_ready, e_ready);
    chk({tag, " stall"}, stall, e_stall);
    chk({tag, " flush"}, flush, br_taken);
    chk({tag, " busy"}, busy, e_busy);
    chk({tag, " fwd_a"}, fwd_a, m_fa);
    chk({tag, " fwd_b"}, fwd_b, m_fb);
    chk({tag, " cnt16"}, stall_cnt, m_cnt16);
    chk({tag, " cnt4"}, stall_cnt4, m_cnt4);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    check_cycle(tag);
    advance();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit v; int rs; bit urs; int rt; bit urt; bit wr; int rd; bit ld; bit br;
    bit r; bit s; bit f; bit b; int fa; int fb;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit v, input int rs, input bit urs, input int rt,
                              input bit urt, input bit wr, input int rd, input bit ld,
                              input bit br, input bit r, input bit s, input bit f,
                              input bit b, input int fa, input int fb);
    vec_t x;
    x.v = v; x.rs = rs; x.urs = urs; x.rt = rt; x.urt = urt; x.wr = wr; x.rd = rd;
    x.ld = ld; x.br = br; x.r = r; x.s = s; x.f = f; x.b = b; x.fa = fa; x.fb = fb;
    tbl.push_back(x);
  endfunction

  function automatic void fill_table();
`ifdef MIPS_HAZ_FWD_EN
    // load-use: one stall, then issue forwarding from stage 2
    add(1,1,1,0,0,1,5,1,0, 1,0,0,0,0,0);
    add(1,5,1,1,1,1,6,0,0, 0,1,0,1,0,0);
    add(1,5,1,1,1,1,6,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,2,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    // ALU back-to-back: no stall, fwd_b = 1
    add(1,1,1,2,1,1,3,0,0, 1,0,0,0,0,0);
    add(1,1,1,3,1,1,4,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,1);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
`else
    // load-use: DEPTH stalls, no forwarding
    add(1,1,1,0,0,1,5,1,0, 1,0,0,0,0,0);
    add(1,5,1,1,1,1,6,0,0, 0,1,0,1,0,0);
    add(1,5,1,1,1,1,6,0,0, 0,1,0,1,0,0);
    add(1,5,1,1,1,1,6,0,0, 1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    // ALU back-to-back: two stalls, fwd_b = 0
    add(1,1,1,2,1,1,3,0,0, 1,0,0,0,0,0);
    add(1,1,1,3,1,1,4,0,0, 0,1,0,1,0,0);
    add(1,1,1,3,1,1,4,0,0, 0,1,0,1,0,0);
    add(1,1,1,3,1,1,4,0,0, 1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
`endif
    // register 0: never hazards, never occupies the scoreboard
    add(1,1,1,2,1,1,0,0,0, 1,0,0,0,0,0);
    add(1,0,1,0,1,1,7,0,0, 1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    // taken branch with load-use pending: kill, no stall, no entry for r9
    add(1,1,1,0,0,1,5,1,0, 1,0,0,0,0,0);
    add(1,5,1,0,0,1,9,0,1, 0,0,1,1,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0);
    add(1,9,1,0,0,0,0,0,0, 1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endfunction

  // ---------------- main ----------------
  initial begin
    bit hold;
    int guard;
    string tag;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    // reset state while held in reset
    chk("reset busy", busy, 0);
    chk("reset cnt", stall_cnt, 0);
    chk("reset fwd_a", fwd_a, 0);
    do_reset();

    fill_table();
    foreach (tbl[i]) begin
      tag = $sformatf("row%0d", i);
      drive(tbl[i].v, tbl[i].rs, tbl[i].urs, tbl[i].rt, tbl[i].urt,
            tbl[i].wr, tbl[i].rd, tbl[i].ld, tbl[i].br);
      check_cycle(tag);
      chk({tag, " tbl_ready"}, id_ready, tbl[i].r);
      chk({tag, " tbl_stall"}, stall, tbl[i].s);
      chk({tag, " tbl_flush"}, flush, tbl[i].f);
      chk({tag, " tbl_busy"}, busy, tbl[i].b);
      chk({tag, " tbl_fwd_a"}, fwd_a, tbl[i].fa);
      chk({tag, " tbl_fwd_b"}, fwd_b, tbl[i].fb);
      advance();
    end
    chk("table stall total", stall_cnt, FWD ? 1 : 4);

    // reset in the middle of a load-use stall
    drive(1, 1, 1, 0, 0, 1, 5, 1, 0);
    step("rst lw");
    drive(1, 5, 1, 1, 1, 1, 6, 0, 0);
    check_cycle("rst use");
    chk("rst pre stall", stall, 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst busy", busy, 0);
    chk("rst cnt", stall_cnt, 0);
    chk("rst cnt4", stall_cnt4, 0);
    chk("rst fwd_a", fwd_a, 0);
    rst_n = 1'b1;
    #1;
    model_eval();
    chk("rst ready", id_ready, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst after");

    // counter saturation on the 4-bit instance
    do_reset();
    guard = 0;
    while (m_cnt16 < 20 && guard < 200) begin
      drive(1, 1, 1, 0, 0, 1, 7, 1, 0);
      step("sat lw");
      drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
      do begin
        step("sat use");
        guard++;
      end while (e_stall && guard < 200);
    end
    if (guard >= 200) chk("sat bound", guard, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sat idle");
    chk("sat cnt4", stall_cnt4, 15);
    chk("sat cnt16", stall_cnt, m_cnt16);
    step("sat hold");
    chk("sat cnt4 hold", stall_cnt4, 15);

    // randomized run against the model
    do_reset();
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        drive($urandom_range(7) != 0, $urandom_range(7), $urandom_range(1),
              $urandom_range(7), $urandom_range(1), $urandom_range(3) != 0,
              $urandom_range(7), $urandom_range(2) == 0, 0);
      end
      br_taken = ($urandom_range(9) == 0);
      step($sformatf("rnd%0d", n));
      hold = e_stall;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mips_hazard_unit.md
# mips_hazard_unit

Parametrised pipeline interlock for the MIPS32 pipeline. It keeps a scoreboard of in-flight register writers between ID and WB, and from it:
- stalls PC and IF_ID on read-after-write hazards;
- kills the ID instruction and flushes IF_ID on a taken branch;
- optionally drives EX-stage operand forwarding selects.

It sits beside the ID_EX register and gates its load, with a saturating stall counter for performance debug.

## Interface
- `REG_AW`, 5, register-address width (32 registers; register 0 never hazards)
- `DEPTH`, 2, tracked stages after ID and before WB (EX, MEM, ...); legal 2..4
- `CNT_W`, 16, stall counter width
- `FS_W`, derived `$clog2(DEPTH+1)`, forwarding-select width; not overridable
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID stage holds a live instruction
- `id_rs`, `id_rt`  in  REG_AW  source registers of the ID instruction
- `id_use_rs`, `id_use_rt`  in  1  instruction actually reads rs / rt
- `id_wr`  in  1  instruction writes a register
- `id_rd`  in  REG_AW  destination register
- `id_load`  in  1  instruction is a load
- `br_taken`  in  1  branch resolved taken in EX this cycle
- `id_ready`  out  1  ID instruction issues to EX at this edge
- `stall`  out  1  hold PC and IF_ID; equals `id_valid & ~id_ready & ~br_taken`
- `flush`  out  1  clear IF_ID and insert a bubble into ID_EX; equals `br_taken`
- `fwd_a`, `fwd_b`  out  FS_W  EX operand A/B source: 0 = ID_EX register value, k = output of tracked stage k (1..DEPTH)
- `busy`  out  1  any scoreboard entry valid
- `stall_cnt`  out  CNT_W  cycles with `stall` = 1, saturating

## Operation
- Scoreboard `sb[0..DEPTH-1]`: each entry holds {v, rd, ld}. `sb[0]` is the instruction in EX; `sb[i]` is the stage i beyond EX.
- Shift on every edge:
  - `sb[i] <= sb[i-1]`.
  - `sb[0] <=` {1, id_rd, id_load} when `id_ready & id_wr & id_rd!=0`, otherwise a bubble (v = 0).
- Register bank write-through in ID is a datapath responsibility. A writer leaving `sb[DEPTH-1]` is in WB and never causes a hazard.
- Match rule: source s matches entry j when `id_use_s & id_valid & sb[j].v & sb[j].rd==s & s!=0`.
- `id_ready = id_valid & ~br_taken & ~hazard`. The hazard term depends on the build; see Configuration.
- Branch priority: `br_taken` overrides everything.
  - The ID instruction is killed (no issue, no stall).
  - The EX instruction (the branch) keeps its entry.
  - Younger entries do not exist, because the IF_ID instruction is flushed.
- Forwarding selects are registered. They take effect in the cycle the instruction is in EX.
  - On issue: `fwd_x <=` (index of the youngest matching entry) + 1, or 0 if there is no match.
  - On bubble: `fwd_x <= 0`.
- `stall_cnt` increments each cycle `stall` = 1 and holds at all-ones.

## Timing
- `id_ready`, `stall`, `flush` and `busy` are combinational from the inputs and the current scoreboard. There are no registered-path delays.
- `fwd_a` and `fwd_b` are valid one cycle after issue, aligned with EX.
- Load-use penalty: exactly 1 stall cycle with FWD_EN, at most DEPTH stall cycles without it.
- Simultaneous `br_taken` and hazard: `flush` = 1, `stall` = 0, the counter does not increment.
- Stall with an issue-blocked instruction: a bubble enters `sb[0]` and the older entries still shift, so the hazard clears by shifting.
- Reset, asynchronous, at any time including mid-stall:
  - all `sb` entries invalid;
  - `fwd_a` = `fwd_b` = 0;
  - `stall_cnt` = 0;
  - hence `busy` = 0 and `id_ready = id_valid & ~br_taken`.

## Configuration
- `MIPS_HAZ_FWD_EN` defined (forwarding build):
  - hazard only when a match is on `sb[0]` with `ld` = 1 (load-use);
  - every other match is resolved by the forwarding selects.
- `MIPS_HAZ_FWD_EN` undefined (interlock-only build):
  - hazard on any match on any entry;
  - `fwd_a` and `fwd_b` are tied to 0.

## Test plan
All scenarios use `DEPTH` = 2.
- Reset mid-stall: load r5, then a user of r5 stalls; `rst_n` pulses low → `busy` = 0, `stall_cnt` = 0 immediately, and the next cycle `id_ready` = 1.
- Load-use, FWD_EN: `lw r5`, then `add r6,r5,r1` → `stall` = 1 for 1 cycle; then issue with `fwd_a` = 2 the next cycle; `stall_cnt` = 1.
- ALU back-to-back, FWD_EN: `add r3`, then `sub r4,r1,r3` → no stall, `fwd_b` = 1. Without FWD_EN → 2 stall cycles, `fwd_b` = 0.
- Register 0: `add r0`, then a user of r0 → no stall, `fwd` = 0, and `busy` stays 0 after the producer issues.
- Branch with a pending hazard: `lw r5` in EX, with `br_taken` = 1 while a user of r5 is in ID → `flush` = 1, `stall` = 0, no increment, and the ID instruction never enters `sb`.
- Counter saturation: `CNT_W` = 4 with 20 forced stall cycles → `stall_cnt` = 15 and holds.
